// File: rtl/station_cmd_ctrl.sv
// station_cmd_ctrl: destination command sequencer with barcode arrival detection and no-barcode watchdog.
// Optional obstacle buzzer divider enabled by defining STATION_CMD_BUZZ_EN.
module station_cmd_ctrl #(
  parameter int TIMEOUT_CYC = 4000000,
  parameter int BUZZ_DIV = 12500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd,
  input  logic       cmd_rdy,
  output logic       clr_cmd_rdy,
  input  logic [7:0] ID,
  input  logic       ID_vld,
  output logic       clr_ID_vld,
  input  logic       OK2Move,
  output logic       go,
  output logic       in_transit,
  output logic       arrived,
  output logic       timeout,
  output logic       buzz,
  output logic       buzz_n
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic {IDLE, TRANSIT} state_t;
  state_t state_q, state_d;
  logic [5:0] dest_q, dest_d;
  logic [TW-1:0] timer_q, timer_d;
  logic clr_cmd_q, clr_cmd_d, clr_id_q, clr_id_d;
  logic arrived_q, arrived_d, timeout_q, timeout_d;
  logic cmd_v, id_v, hit;
  if (TIMEOUT_CYC < 2 || BUZZ_DIV < 1) begin : g_bad_param
    $error("station_cmd_ctrl: TIMEOUT_CYC must be >= 2 and BUZZ_DIV >= 1");
  end
  // An ack in flight masks the still-high request so it is not consumed twice.
  assign cmd_v = cmd_rdy & ~clr_cmd_q;
  assign id_v = ID_vld & ~clr_id_q;
  assign hit = (ID[7:6] == 2'b00) && (ID[5:0] == dest_q);
  assign in_transit = (state_q == TRANSIT);
  assign go = in_transit & OK2Move;
  assign clr_cmd_rdy = clr_cmd_q;
  assign clr_ID_vld = clr_id_q;
  assign arrived = arrived_q;
  assign timeout = timeout_q;
  always_comb begin
    state_d = state_q;
    dest_d = dest_q;
    timer_d = timer_q;
    clr_cmd_d = cmd_v;
    clr_id_d = id_v;
    arrived_d = 1'b0;
    timeout_d = 1'b0;
    if (cmd_v) begin
      if (cmd[7:6] == 2'b01) begin
        state_d = TRANSIT;
        dest_d = cmd[5:0];
        timer_d = '0;
      end else if (cmd[7:6] == 2'b00) state_d = IDLE;
    end else if (id_v) begin
      if (in_transit && hit) begin
        state_d = IDLE;
        arrived_d = 1'b1;
      end else timer_d = '0;
    end else if (go) begin
      if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        timeout_d = 1'b1;
        timer_d = '0;
      end else timer_d = timer_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dest_q <= '0;
      timer_q <= '0;
      clr_cmd_q <= 1'b0;
      clr_id_q <= 1'b0;
      arrived_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q <= dest_d;
      timer_q <= timer_d;
      clr_cmd_q <= clr_cmd_d;
      clr_id_q <= clr_id_d;
      arrived_q <= arrived_d;
      timeout_q <= timeout_d;
    end
  end
`ifdef STATION_CMD_BUZZ_EN
  localparam int DW = $clog2(BUZZ_DIV + 1);
  logic [DW-1:0] div_q, div_d;
  logic buzz_q, buzz_d, blocked, wrap;
  always_comb begin
    blocked = in_transit & ~OK2Move;
    wrap = (div_q == DW'(BUZZ_DIV - 1));
    div_d = (blocked && !wrap) ? div_q + 1'b1 : '0;
    buzz_d = blocked ? buzz_q ^ wrap : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      buzz_q <= 1'b0;
    end else begin
      div_q <= div_d;
      buzz_q <= buzz_d;
    end
  end
  assign buzz = buzz_q;
`else
  assign buzz = 1'b0;
`endif
  assign buzz_n = ~buzz;
endmodule
